// File: rtl/ibuf_rd_collector_if.sv
// ibuf_rd_collector_if: R-channel, tile-buffer write port and tile handshake bundle.
interface ibuf_rd_collector_if #(
    parameter int DW = 64,
    parameter int CW = 4,
    parameter int RW = 3
);
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          wr_en;
    logic          wr_slot;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic          tile_fill;
    logic          tile_valid;
    logic          tile_slot;
    logic          tile_done;
    logic          err_len;
    logic          err_resp;

    modport master (
        output rvalid, rdata, rresp, rlast, tile_done,
        input  rready, wr_en, wr_slot, wr_row, wr_col, wr_data,
        input  tile_fill, tile_valid, tile_slot, err_len, err_resp
    );

    modport slave (
        input  rvalid, rdata, rresp, rlast, tile_done,
        output rready, wr_en, wr_slot, wr_row, wr_col, wr_data,
        output tile_fill, tile_valid, tile_slot, err_len, err_resp
    );
endinterface

// File: rtl/ibuf_rd_collector.sv
// ibuf_rd_collector: collects AXI R beats into a ping-pong ROWS x BURST tile buffer.
module ibuf_rd_collector #(
    parameter int DW    = 64,
    parameter int BURST = 16,
    parameter int ROWS  = 5,
    parameter int CW    = 4,
    parameter int RW    = 3
) (
    input logic clk,
    input logic rst,
    ibuf_rd_collector_if.slave bus
);
    logic [CW-1:0] beat_q, beat_d;
    logic [RW-1:0] row_q, row_d;
    logic          wslot_q, wslot_d, rslot_q, rslot_d;
    logic [1:0]    full_q, full_d;
    logic          err_len_q, err_len_d, err_resp_q, err_resp_d;
    logic          wr_en_q, wr_slot_q, fill_q;
    logic [RW-1:0] wr_row_q;
    logic [CW-1:0] wr_col_q;
    logic [DW-1:0] wr_data_q;
    logic          acc, last_beat, last_row, cmpl, done;

    assign bus.rready = (full_q != 2'd2) && !err_len_q;

    always_comb begin
        acc        = bus.rvalid && bus.rready;
        last_beat  = beat_q == CW'(BURST - 1);
        last_row   = row_q == RW'(ROWS - 1);
        cmpl       = acc && last_beat && last_row;
        done       = bus.tile_done && (full_q != 2'd0);
        beat_d     = acc ? (last_beat ? '0 : beat_q + CW'(1)) : beat_q;
        row_d      = (acc && last_beat) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
        wslot_d    = wslot_q ^ cmpl;
        rslot_d    = rslot_q ^ done;
        // simultaneous completion and release cancel out in the occupancy count
        full_d     = full_q + {1'b0, cmpl} - {1'b0, done};
        err_len_d  = err_len_q | (acc && (bus.rlast != last_beat));
        err_resp_d = err_resp_q | (acc && (bus.rresp != 2'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= '0;
            row_q      <= '0;
            wslot_q    <= 1'b0;
            rslot_q    <= 1'b0;
            full_q     <= '0;
            err_len_q  <= 1'b0;
            err_resp_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_slot_q  <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_data_q  <= '0;
            fill_q     <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            row_q      <= row_d;
            wslot_q    <= wslot_d;
            rslot_q    <= rslot_d;
            full_q     <= full_d;
            err_len_q  <= err_len_d;
            err_resp_q <= err_resp_d;
            wr_en_q    <= acc;
            fill_q     <= cmpl;
            if (acc) begin
                wr_slot_q <= wslot_q;
                wr_row_q  <= row_q;
                wr_col_q  <= beat_q;
                wr_data_q <= bus.rdata;
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_slot    = wr_slot_q;
    assign bus.wr_row     = wr_row_q;
    assign bus.wr_col     = wr_col_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.tile_fill  = fill_q;
    assign bus.tile_valid = full_q != 2'd0;
    assign bus.tile_slot  = rslot_q;
    assign bus.err_len    = err_len_q;
    assign bus.err_resp   = err_resp_q;
endmodule

// File: tb/tb_ibuf_rd_collector.sv
// tb_ibuf_rd_collector: directed bench; writes are matched against an expected-write queue.
module tb_ibuf_rd_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    logic [71:0] q[$];
    logic [71:0] e_w;

    always #5 clk = ~clk;

    ibuf_rd_collector_if #(.DW(64), .CW(4), .RW(3)) bus ();
    ibuf_rd_collector dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // each accepted beat shows up as exactly one write, in order
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            if (q.size() == 0) chk("wr_unexp", 72'd1, 72'd0);
            else begin
                e_w = q.pop_front();
                chk("wr", {bus.wr_slot, bus.wr_row, bus.wr_col, bus.wr_data}, e_w);
            end
        end
    end

    task automatic beat(input logic [63:0] d, input logic l, input logic [1:0] rs);
        bus.rvalid = 1'b1;
        bus.rdata  = d;
        bus.rlast  = l;
        bus.rresp  = rs;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'd0;
    endtask

    task automatic beat_exp(input logic [63:0] d, input logic l, input logic [1:0] rs,
                            input logic s, input logic [2:0] r, input logic [3:0] c);
        q.push_back({s, r, c, d});
        beat(d, l, rs);
    endtask

    task automatic send_tile(input logic s, input int base, input int bad);
        for (int i = 0; i < 80; i++) begin
            beat_exp(64'(base + i), (i % 16) == 15, (i == bad) ? 2'd2 : 2'd0, s, 3'(i / 16), 4'(i % 16));
            chk("fill", {71'd0, bus.tile_fill}, {71'd0, i == 79});
        end
    endtask

    task automatic release_tile();
        bus.tile_done = 1'b1;
        @(negedge clk);
        bus.tile_done = 1'b0;
    endtask

    initial begin
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rlast = 1'b0;
        bus.rresp = 2'd0;
        bus.tile_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", {bus.rready, bus.wr_en, bus.tile_fill, bus.tile_valid, bus.tile_slot, bus.err_len, bus.err_resp}, 72'b1000000);
        chk("rst_wr", {bus.wr_slot, bus.wr_row, bus.wr_col, bus.wr_data}, 72'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_wr", {71'd0, bus.wr_en}, 72'd0);

        send_tile(1'b0, 0, -1);
        @(negedge clk);
        chk("t1_state", {bus.tile_fill, bus.tile_valid, bus.tile_slot, bus.rready}, 72'b0101);
        chk("t1_nwr", 72'(wr_cnt), 72'd80);

        send_tile(1'b1, 80, -1);
        chk("pp_rdy", {71'd0, bus.rready}, 72'd0);
        chk("pp_state", {bus.tile_valid, bus.tile_slot}, 72'b10);
        beat(64'd999, 1'b0, 2'd0);
        beat(64'd999, 1'b0, 2'd0);
        chk("pp_hold", {bus.rready, bus.err_len}, 72'b00);
        release_tile();
        chk("pp_rel", {bus.tile_valid, bus.tile_slot, bus.rready}, 72'b111);
        beat_exp(64'd500, 1'b0, 2'd0, 1'b0, 3'd0, 4'd0);

        for (int i = 1; i < 80; i++) begin
            bus.tile_done = (i == 79);
            beat_exp(64'(500 + i), (i % 16) == 15, 2'd0, 1'b0, 3'(i / 16), 4'(i % 16));
            bus.tile_done = 1'b0;
            chk("sim_rdy", {71'd0, bus.rready}, 72'd1);
        end
        chk("sim_fill", {bus.tile_fill, bus.tile_valid, bus.tile_slot}, 72'b110);
        release_tile();
        chk("sim_rel", {bus.tile_valid, bus.tile_slot, bus.rready}, 72'b011);

        send_tile(1'b1, 300, 3);
        chk("resp_state", {bus.tile_valid, bus.tile_slot, bus.err_resp, bus.err_len}, 72'b1110);
        release_tile();
        chk("resp_rel", {bus.tile_valid, bus.tile_slot}, 72'b00);

        for (int i = 0; i < 7; i++) beat_exp(64'(400 + i), 1'b0, 2'd0, 1'b0, 3'd0, 4'(i));
        chk("len_pre", {bus.err_len, bus.rready}, 72'b01);
        beat_exp(64'd407, 1'b1, 2'd0, 1'b0, 3'd0, 4'd7);
        chk("len_err", {bus.err_len, bus.rready}, 72'b10);
        beat(64'd999, 1'b0, 2'd0);
        beat(64'd999, 1'b1, 2'd0);
        chk("len_stick", {bus.err_len, bus.rready, bus.err_resp}, 72'b101);

        bus.rvalid = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_out", {bus.rready, bus.wr_en, bus.tile_fill, bus.tile_valid, bus.tile_slot, bus.err_len, bus.err_resp}, 72'b1000000);
        bus.rvalid = 1'b0;
        rst = 1'b0;
        beat_exp(64'd1, 1'b0, 2'd0, 1'b0, 3'd0, 4'd0);
        beat_exp(64'd2, 1'b0, 2'd0, 1'b0, 3'd0, 4'd1);
        bus.rvalid = 1'b1;
        bus.rdata = 64'd3;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr", {71'd0, bus.wr_en}, 72'd0);
        bus.rvalid = 1'b0;
        rst = 1'b0;
        beat_exp(64'd4, 1'b0, 2'd0, 1'b0, 3'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("q_empty", 72'(q.size()), 72'd0);
        chk("nwr", 72'(wr_cnt), 72'd331);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
